// File: rtl/square_round_ctrl.sv
// Round sequencer for the square-hunt game: pick a location, draw the square, wait for a hit
// or timeout, erase it, keep score. Optional timeout/miss/game-over logic under ROUND_TIMEOUT_EN.
module square_round_ctrl #(
    parameter int SQ_SIZE        = 16,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int MAX_MISSES     = 3,
    parameter int SCORE_W        = 8,
    localparam int MISS_W        = ($clog2(MAX_MISSES + 1) < 2) ? 2 : $clog2(MAX_MISSES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_en,
    output logic               pick_start,
    input  logic               pick_done,
    input  logic [10:0]        pick_x,
    input  logic [10:0]        pick_y,
    output logic               draw_start,
    input  logic               draw_done,
    output logic [10:0]        draw_x,
    output logic [10:0]        draw_y,
    output logic               draw_colour,
    input  logic [10:0]        cursor_x,
    input  logic [10:0]        cursor_y,
    input  logic               click,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_PICK_REL, S_DRAW, S_ACTIVE, S_ERASE, S_CHECK, S_OVER
    } state_t;

    state_t             state_r, state_nxt_s;
    logic               pick_start_r, pick_start_nxt_s;
    logic               draw_start_r, draw_start_nxt_s;
    logic [10:0]        draw_x_r, draw_x_nxt_s;
    logic [10:0]        draw_y_r, draw_y_nxt_s;
    logic               draw_colour_r, draw_colour_nxt_s;
    logic [SCORE_W-1:0] score_r, score_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               hit_s;
    logic [11:0]        x_lo_s, x_hi_s, y_lo_s, y_hi_s, cur_x_s, cur_y_s;

`ifdef ROUND_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TIMER_W-1:0] timer_r, timer_nxt_s;
    logic [MISS_W-1:0]  misses_r, misses_nxt_s;
    logic               game_over_r, game_over_nxt_s;
`endif

    // 12-bit bounds so a square near the right/bottom edge cannot wrap
    assign x_lo_s  = {1'b0, draw_x_r};
    assign y_lo_s  = {1'b0, draw_y_r};
    assign x_hi_s  = x_lo_s + 12'(SQ_SIZE - 1);
    assign y_hi_s  = y_lo_s + 12'(SQ_SIZE - 1);
    assign cur_x_s = {1'b0, cursor_x};
    assign cur_y_s = {1'b0, cursor_y};
    assign hit_s   = click && (cur_x_s >= x_lo_s) && (cur_x_s <= x_hi_s) &&
                     (cur_y_s >= y_lo_s) && (cur_y_s <= y_hi_s);

    // Next-state and next-register-value logic for the round sequencer
    always_comb begin
        state_nxt_s       = state_r;
        pick_start_nxt_s  = pick_start_r;
        draw_start_nxt_s  = 1'b0;
        draw_x_nxt_s      = draw_x_r;
        draw_y_nxt_s      = draw_y_r;
        draw_colour_nxt_s = draw_colour_r;
        score_nxt_s       = score_r;
`ifdef ROUND_TIMEOUT_EN
        timer_nxt_s       = timer_r;
        misses_nxt_s      = misses_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (game_en) begin
                    state_nxt_s      = S_PICK;
                    pick_start_nxt_s = 1'b1;
                    score_nxt_s      = {SCORE_W{1'b0}};
`ifdef ROUND_TIMEOUT_EN
                    misses_nxt_s     = {MISS_W{1'b0}};
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_PICK: begin
                if (pick_done) begin
                    draw_x_nxt_s     = pick_x;
                    draw_y_nxt_s     = pick_y;
                    pick_start_nxt_s = 1'b0;
                    state_nxt_s      = S_PICK_REL;
                end else begin
                    pick_start_nxt_s = 1'b1;
                end
            end
            S_PICK_REL: begin
                if (!pick_done) begin
                    draw_start_nxt_s  = 1'b1;
                    draw_colour_nxt_s = 1'b1;
                    state_nxt_s       = S_DRAW;
                end else begin
                    state_nxt_s = S_PICK_REL;
                end
            end
            S_DRAW: begin
                if (draw_done) begin
`ifdef ROUND_TIMEOUT_EN
                    timer_nxt_s = {TIMER_W{1'b0}};
`endif
                    state_nxt_s = S_ACTIVE;
                end else begin
                    state_nxt_s = S_DRAW;
                end
            end
            S_ACTIVE: begin
                // a hit on the timeout cycle still counts as a hit
                if (hit_s) begin
                    if (score_r != {SCORE_W{1'b1}}) begin
                        score_nxt_s = score_r + {{(SCORE_W-1){1'b0}}, 1'b1};
                    end else begin
                        score_nxt_s = score_r;
                    end
                    draw_start_nxt_s  = 1'b1;
                    draw_colour_nxt_s = 1'b0;
                    state_nxt_s       = S_ERASE;
`ifdef ROUND_TIMEOUT_EN
                end else if (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    misses_nxt_s      = misses_r + {{(MISS_W-1){1'b0}}, 1'b1};
                    draw_start_nxt_s  = 1'b1;
                    draw_colour_nxt_s = 1'b0;
                    state_nxt_s       = S_ERASE;
                end else begin
                    timer_nxt_s = timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
`else
                end else begin
                    state_nxt_s = S_ACTIVE;
`endif
                end
            end
            S_ERASE: begin
                if (draw_done) begin
                    state_nxt_s = S_CHECK;
                end else begin
                    state_nxt_s = S_ERASE;
                end
            end
            S_CHECK: begin
`ifdef ROUND_TIMEOUT_EN
                if (misses_r == MISS_W'(MAX_MISSES)) begin
                    state_nxt_s = S_OVER;
                end else
`endif
                if (!game_en) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s      = S_PICK;
                    pick_start_nxt_s = 1'b1;
                end
            end
            S_OVER: begin
                if (!game_en) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_OVER;
                end
            end
            default: begin
                state_nxt_s      = S_IDLE;
                pick_start_nxt_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != S_IDLE) && (state_nxt_s != S_OVER);
`ifdef ROUND_TIMEOUT_EN
        game_over_nxt_s = (state_nxt_s == S_OVER);
`endif
    end

    // State and registered outputs; synchronous reset drops every handshake at once
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            pick_start_r  <= 1'b0;
            draw_start_r  <= 1'b0;
            draw_x_r      <= 11'd0;
            draw_y_r      <= 11'd0;
            draw_colour_r <= 1'b0;
            score_r       <= {SCORE_W{1'b0}};
            busy_r        <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
            timer_r       <= {TIMER_W{1'b0}};
            misses_r      <= {MISS_W{1'b0}};
            game_over_r   <= 1'b0;
`endif
        end else begin
            state_r       <= state_nxt_s;
            pick_start_r  <= pick_start_nxt_s;
            draw_start_r  <= draw_start_nxt_s;
            draw_x_r      <= draw_x_nxt_s;
            draw_y_r      <= draw_y_nxt_s;
            draw_colour_r <= draw_colour_nxt_s;
            score_r       <= score_nxt_s;
            busy_r        <= busy_nxt_s;
`ifdef ROUND_TIMEOUT_EN
            timer_r       <= timer_nxt_s;
            misses_r      <= misses_nxt_s;
            game_over_r   <= game_over_nxt_s;
`endif
        end
    end

    assign pick_start  = pick_start_r;
    assign draw_start  = draw_start_r;
    assign draw_x      = draw_x_r;
    assign draw_y      = draw_y_r;
    assign draw_colour = draw_colour_r;
    assign score       = score_r;
    assign busy        = busy_r;
`ifdef ROUND_TIMEOUT_EN
    assign misses      = misses_r;
    assign game_over   = game_over_r;
`else
    assign misses      = {MISS_W{1'b0}};
    assign game_over   = 1'b0;
`endif

endmodule

// File: tb/tb_square_round_ctrl.sv
// Directed bench for square_round_ctrl with behavioural picker and drawer models.
module tb_square_round_ctrl;

    logic        clk = 1'b0;
    logic        reset, game_en, pick_start, pick_done, draw_start, draw_done;
    logic [10:0] pick_x, pick_y, draw_x, draw_y, cursor_x, cursor_y;
    logic        draw_colour, click, game_over, busy;
    logic [7:0]  score;
    logic [1:0]  misses;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int draw_cnt = 0;
    int pcnt = 0;
    int dcnt = 0;
    logic pstart_prev = 1'b0;

    square_round_ctrl #(.SQ_SIZE(16), .TIMEOUT_CYCLES(100), .MAX_MISSES(3), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .game_en(game_en),
        .pick_start(pick_start), .pick_done(pick_done), .pick_x(pick_x), .pick_y(pick_y),
        .draw_start(draw_start), .draw_done(draw_done), .draw_x(draw_x), .draw_y(draw_y),
        .draw_colour(draw_colour), .cursor_x(cursor_x), .cursor_y(cursor_y), .click(click),
        .score(score), .misses(misses), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // Picker and drawer models plus handshake-rule monitor, all on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            pick_done = 1'b0; pcnt = 0; dcnt = 0; draw_done = 1'b0;
        end else begin
            if (pstart_prev && !pick_start && !pick_done) viol++;
            if (pick_start && !pick_done) begin
                pcnt++;
                if (pcnt == 3) begin pick_done = 1'b1; pcnt = 0; end
            end else if (!pick_start && pick_done) begin
                pcnt++;
                if (pcnt == 2) begin pick_done = 1'b0; pcnt = 0; end
            end
            draw_done = 1'b0;
            if (dcnt != 0) begin
                dcnt--;
                if (dcnt == 0) draw_done = 1'b1;
            end
            if (draw_start) begin
                if (dcnt != 0 || pick_done) viol++;
                dcnt = 3;
                draw_cnt++;
            end
        end
        pstart_prev = pick_start;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_draw_done(input string tag);
        int n = 0;
        do begin step(); n++; end while (!draw_done && n < 300);
        check_eq({tag, "_timeout"}, int'(draw_done), 1);
    endtask

    task automatic click_at(input int x, input int y);
        cursor_x = 11'(x); cursor_y = 11'(y); click = 1'b1;
        step();
        click = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pick_start"}, int'(pick_start), 0);
        check_eq({tag, "_draw_start"}, int'(draw_start), 0);
        check_eq({tag, "_draw_x"}, int'(draw_x), 0);
        check_eq({tag, "_draw_y"}, int'(draw_y), 0);
        check_eq({tag, "_colour"}, int'(draw_colour), 0);
        check_eq({tag, "_score"}, int'(score), 0);
        check_eq({tag, "_misses"}, int'(misses), 0);
        check_eq({tag, "_game_over"}, int'(game_over), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic timeout_round(input int exp_miss);
        wait_draw_done("to_draw");
        step();
        repeat (99) step();
        check_eq("to_before_misses", int'(misses), exp_miss - 1);
        check_eq("to_before_erase", int'(draw_start), 0);
        step();
        check_eq("to_misses", int'(misses), exp_miss);
        check_eq("to_erase_start", int'(draw_start), 1);
        check_eq("to_erase_colour", int'(draw_colour), 0);
        wait_draw_done("to_erase");
    endtask

    initial begin
        reset = 1'b1; game_en = 1'b0; click = 1'b0;
        cursor_x = 11'd0; cursor_y = 11'd0;
        pick_x = 11'd345; pick_y = 11'd343;
        repeat (3) step();
        check_reset_vals("rst");
        reset = 1'b0;
        step();

        // round 1: boundary clicks, then inclusive top-left corner hit
        game_en = 1'b1;
        step();
        check_eq("r1_pick_start", int'(pick_start), 1);
        check_eq("r1_busy", int'(busy), 1);
        wait_draw_done("r1_draw");
        check_eq("r1_draw_x", int'(draw_x), 345);
        check_eq("r1_draw_y", int'(draw_y), 343);
        check_eq("r1_colour", int'(draw_colour), 1);
        check_eq("r1_draw_cnt", draw_cnt, 1);
        step();
        click_at(344, 343);
        check_eq("r1_left_miss_score", int'(score), 0);
        check_eq("r1_left_miss_nodraw", int'(draw_start), 0);
        click_at(345, 359);
        check_eq("r1_below_miss_score", int'(score), 0);
        click_at(345, 343);
        check_eq("r1_corner_hit_score", int'(score), 1);
        check_eq("r1_erase_start", int'(draw_start), 1);
        check_eq("r1_erase_colour", int'(draw_colour), 0);
        check_eq("r1_erase_x", int'(draw_x), 345);
        click_at(361, 343);
        check_eq("r1_click_in_erase", int'(score), 1);
        wait_draw_done("r1_erase");

        // round 2: bottom-right inclusive corner hit; outside click afterwards ignored
        wait_draw_done("r2_draw");
        step();
        click_at(360, 358);
        check_eq("r2_hit_score", int'(score), 2);
        check_eq("r2_erase_start", int'(draw_start), 1);
        click_at(361, 343);
        check_eq("r2_outside_ignored", int'(score), 2);
        check_eq("r2_misses", int'(misses), 0);
        wait_draw_done("r2_erase");

`ifdef ROUND_TIMEOUT_EN
        timeout_round(1);
        // hit on the exact timeout cycle: hit wins
        wait_draw_done("r4_draw");
        step();
        repeat (99) step();
        click_at(350, 350);
        check_eq("r4_hit_at_timeout_score", int'(score), 3);
        check_eq("r4_hit_at_timeout_misses", int'(misses), 1);
        check_eq("r4_erase_start", int'(draw_start), 1);
        wait_draw_done("r4_erase");
        timeout_round(2);
        timeout_round(3);
        step();
        step();
        check_eq("over_game_over", int'(game_over), 1);
        check_eq("over_busy", int'(busy), 0);
        check_eq("over_score", int'(score), 3);
        check_eq("over_pick_start", int'(pick_start), 0);
        game_en = 1'b0;
        step();
        check_eq("idle_game_over", int'(game_over), 0);
        check_eq("idle_score_kept", int'(score), 3);
        check_eq("idle_misses_kept", int'(misses), 3);
        game_en = 1'b1;
`else
        check_eq("notimeout_game_over", int'(game_over), 0);
`endif

        // reset while the drawer is filling
        begin
            int n = 0;
            do begin step(); n++; end while (!draw_start && n < 400);
            check_eq("rd_draw_seen", int'(draw_start), 1);
        end
        check_eq("rd_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        check_reset_vals("rd");
        reset = 1'b0;
        step();
        check_eq("rd_restart_pick", int'(pick_start), 1);
        check_eq("rd_restart_score", int'(score), 0);
        wait_draw_done("rd_draw");
        check_eq("rd_draw_x", int'(draw_x), 345);
        check_eq("rd_colour", int'(draw_colour), 1);
        check_eq("handshake_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
